// File: rtl/spu_pkg.sv
// Shared types and defaults for the SPU issue-stage hazard logic.
package spu_pkg;

    localparam int REG_IDX_W        = 7;
    localparam int LAT_W_DEF        = 3;
    localparam int FLUSH_CYCLES_DEF = 2;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    typedef enum logic {
        IDLE,
        FLUSH
    } hz_state_t;

endpackage

// File: rtl/spu_scoreboard.sv
// Per-register pending-write latency counters with two write ports,
// a freeze input and six busy-flag read ports.
module spu_scoreboard
    import spu_pkg::*;
#(
    parameter int NUM_REGS = 128,
    parameter int LAT_W    = LAT_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 freeze,
    input  logic                 we_even,
    input  reg_idx_t             wr_idx_even,
    input  logic [LAT_W-1:0]     wr_lat_even,
    input  logic                 we_odd,
    input  reg_idx_t             wr_idx_odd,
    input  logic [LAT_W-1:0]     wr_lat_odd,
    input  reg_idx_t [5:0]       rd_idx,
    output logic [5:0]           rd_busy
);

    logic [LAT_W-1:0] cnt [NUM_REGS];

    // Writes follow the decrement so an issuing writer overrides; odd is last so it wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
        end else if (!freeze) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - 1'b1;
                end
            end
            if (we_even) begin
                cnt[wr_idx_even] <= wr_lat_even;
            end
            if (we_odd) begin
                cnt[wr_idx_odd] <= wr_lat_odd;
            end
        end
    end

    always_comb begin
        rd_busy = '0;
        for (int unsigned i = 0; i < 6; i++) begin
            rd_busy[i] = (cnt[rd_idx[i]] != '0);
        end
    end

endmodule

// File: rtl/spu_issue_hazard_ctrl.sv
// Issue-stage hazard controller: RAW/intra-pair detection, external freeze
// and mispredict flush sequencing for the dual-issue SPU pipeline.
module spu_issue_hazard_ctrl
    import spu_pkg::*;
#(
    parameter int NUM_REGS     = 128,
    parameter int LAT_W        = LAT_W_DEF,
    parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_REG1,
    input  logic             valid_REG2,
    input  logic             regWriteEnable_REG1,
    input  logic             regWriteEnable_REG2,
    input  logic [6:0]       readRegisterRA_REG1,
    input  logic [6:0]       readRegisterRB_REG1,
    input  logic [6:0]       readRegisterRC_REG1,
    input  logic [6:0]       readRegisterRA_REG2,
    input  logic [6:0]       readRegisterRB_REG2,
    input  logic [6:0]       readRegisterRC_REG2,
    input  logic             useRA_REG1,
    input  logic             useRB_REG1,
    input  logic             useRC_REG1,
    input  logic             useRA_REG2,
    input  logic             useRB_REG2,
    input  logic             useRC_REG2,
    input  logic [6:0]       readRegisterRT_REG1,
    input  logic [6:0]       readRegisterRT_REG2,
    input  logic [LAT_W-1:0] latency_REG1,
    input  logic [LAT_W-1:0] latency_REG2,
    input  logic             mispredict,
    input  logic             stallExternal,
    output logic             stallEven,
    output logic             stallOdd,
    output logic             flushEven,
    output logic             flushOdd,
    output logic             holdDecode,
    output logic             splitIssue,
    output logic             redirectFetch
);

    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FC_W-1:0] FLUSH_LOAD = FC_W'(FLUSH_CYCLES - 1);

    hz_state_t       state, state_next;
    logic [FC_W-1:0] fcnt, fcnt_next;

    reg_idx_t [5:0]  rd_idx;
    logic [5:0]      rd_busy;
    logic [2:0]      use_even, use_odd;
    logic            raw_even, raw_odd, dep_pair;
    logic            flush_active;
    logic            issue_even, issue_odd, freeze;
    logic            we_even, we_odd;

    assign rd_idx   = {readRegisterRC_REG2, readRegisterRB_REG2, readRegisterRA_REG2,
                       readRegisterRC_REG1, readRegisterRB_REG1, readRegisterRA_REG1};
    assign use_even = {useRC_REG1, useRB_REG1, useRA_REG1};
    assign use_odd  = {useRC_REG2, useRB_REG2, useRA_REG2};

    assign raw_even = valid_REG1 && |(rd_busy[2:0] & use_even);
    assign raw_odd  = valid_REG2 && |(rd_busy[5:3] & use_odd);
    assign dep_pair = valid_REG1 && valid_REG2 && regWriteEnable_REG1 &&
                      ((useRA_REG2 && (readRegisterRA_REG2 == readRegisterRT_REG1)) ||
                       (useRB_REG2 && (readRegisterRB_REG2 == readRegisterRT_REG1)) ||
                       (useRC_REG2 && (readRegisterRC_REG2 == readRegisterRT_REG1)));

    assign flush_active = (state == FLUSH) || mispredict;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            fcnt  <= '0;
        end else begin
            state <= state_next;
            fcnt  <= fcnt_next;
        end
    end

    always_comb begin
        state_next = state;
        fcnt_next  = fcnt;
        case (state)
            IDLE: begin
                if (mispredict) begin
                    state_next = FLUSH;
                    fcnt_next  = FLUSH_LOAD;
                end
            end
            FLUSH: begin
                if (mispredict) begin
                    fcnt_next = FLUSH_LOAD;
                end else if (fcnt == '0) begin
                    state_next = IDLE;
                end else begin
                    fcnt_next = fcnt - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        stallEven     = 1'b0;
        stallOdd      = 1'b0;
        flushEven     = 1'b0;
        flushOdd      = 1'b0;
        holdDecode    = 1'b0;
        splitIssue    = 1'b0;
        redirectFetch = 1'b0;
        issue_even    = 1'b0;
        issue_odd     = 1'b0;
        freeze        = 1'b0;
        if (reset) begin
            flushEven = 1'b1;
            flushOdd  = 1'b1;
        end else if (flush_active) begin
            flushEven     = 1'b1;
            flushOdd      = 1'b1;
            redirectFetch = (state == IDLE);
        end else if (stallExternal) begin
            stallEven  = 1'b1;
            stallOdd   = 1'b1;
            holdDecode = 1'b1;
            freeze     = 1'b1;
        end else if (raw_even || raw_odd) begin
            flushEven  = 1'b1;
            flushOdd   = 1'b1;
            holdDecode = 1'b1;
        end else if (dep_pair) begin
            issue_even = 1'b1;
            flushOdd   = 1'b1;
            holdDecode = 1'b1;
            splitIssue = 1'b1;
        end else begin
            issue_even = valid_REG1;
            issue_odd  = valid_REG2;
        end
    end

    assign we_even = issue_even && regWriteEnable_REG1;
    assign we_odd  = issue_odd && regWriteEnable_REG2;

    spu_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .LAT_W    (LAT_W)
    ) u_sb (
        .clk         (clk),
        .reset       (reset),
        .freeze      (freeze),
        .we_even     (we_even),
        .wr_idx_even (readRegisterRT_REG1),
        .wr_lat_even (latency_REG1),
        .we_odd      (we_odd),
        .wr_idx_odd  (readRegisterRT_REG2),
        .wr_lat_odd  (latency_REG2),
        .rd_idx      (rd_idx),
        .rd_busy     (rd_busy)
    );

endmodule

// File: tb/tb_spu_issue_hazard_ctrl.sv
// Bench for spu_issue_hazard_ctrl: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_spu_issue_hazard_ctrl;

    localparam int FLUSH_CYCLES = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid_REG1, valid_REG2;
    logic       regWriteEnable_REG1, regWriteEnable_REG2;
    logic [6:0] readRegisterRA_REG1, readRegisterRB_REG1, readRegisterRC_REG1;
    logic [6:0] readRegisterRA_REG2, readRegisterRB_REG2, readRegisterRC_REG2;
    logic       useRA_REG1, useRB_REG1, useRC_REG1;
    logic       useRA_REG2, useRB_REG2, useRC_REG2;
    logic [6:0] readRegisterRT_REG1, readRegisterRT_REG2;
    logic [2:0] latency_REG1, latency_REG2;
    logic       mispredict, stallExternal;
    logic       stallEven, stallOdd, flushEven, flushOdd;
    logic       holdDecode, splitIssue, redirectFetch;

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] obs;
    assign obs = {stallEven, stallOdd, flushEven, flushOdd, holdDecode, splitIssue, redirectFetch};

    always #5 clk = ~clk;

    spu_issue_hazard_ctrl #(
        .NUM_REGS     (128),
        .LAT_W        (3),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) u_dut (
        .clk                 (clk),
        .reset               (reset),
        .valid_REG1          (valid_REG1),
        .valid_REG2          (valid_REG2),
        .regWriteEnable_REG1 (regWriteEnable_REG1),
        .regWriteEnable_REG2 (regWriteEnable_REG2),
        .readRegisterRA_REG1 (readRegisterRA_REG1),
        .readRegisterRB_REG1 (readRegisterRB_REG1),
        .readRegisterRC_REG1 (readRegisterRC_REG1),
        .readRegisterRA_REG2 (readRegisterRA_REG2),
        .readRegisterRB_REG2 (readRegisterRB_REG2),
        .readRegisterRC_REG2 (readRegisterRC_REG2),
        .useRA_REG1          (useRA_REG1),
        .useRB_REG1          (useRB_REG1),
        .useRC_REG1          (useRC_REG1),
        .useRA_REG2          (useRA_REG2),
        .useRB_REG2          (useRB_REG2),
        .useRC_REG2          (useRC_REG2),
        .readRegisterRT_REG1 (readRegisterRT_REG1),
        .readRegisterRT_REG2 (readRegisterRT_REG2),
        .latency_REG1        (latency_REG1),
        .latency_REG2        (latency_REG2),
        .mispredict          (mispredict),
        .stallExternal       (stallExternal),
        .stallEven           (stallEven),
        .stallOdd            (stallOdd),
        .flushEven           (flushEven),
        .flushOdd            (flushOdd),
        .holdDecode          (holdDecode),
        .splitIssue          (splitIssue),
        .redirectFetch       (redirectFetch)
    );

    // Behavioural model: remaining latency per register, remaining flush cycles.
    int  m_cnt [128];
    int  m_left;
    bit  m_ok = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (reset) m_ok = 1;
            if (m_ok) begin : model_step
                logic [6:0] e;
                bit raw_e, raw_o, dep, is_e, is_o, dec;
                e = '0; is_e = 0; is_o = 0; dec = 1;
                if (reset) begin
                    e = 7'b0011000;
                    for (int r = 0; r < 128; r++) m_cnt[r] = 0;
                    m_left = 0;
                    dec = 0;
                end else if (mispredict || m_left > 0) begin
                    e = {4'b0011, 2'b00, (mispredict && m_left == 0)};
                    m_left = mispredict ? FLUSH_CYCLES : m_left - 1;
                end else if (stallExternal) begin
                    e = 7'b1100100;
                    dec = 0;
                end else begin
                    raw_e = valid_REG1 && ((useRA_REG1 && m_cnt[readRegisterRA_REG1] != 0) ||
                                           (useRB_REG1 && m_cnt[readRegisterRB_REG1] != 0) ||
                                           (useRC_REG1 && m_cnt[readRegisterRC_REG1] != 0));
                    raw_o = valid_REG2 && ((useRA_REG2 && m_cnt[readRegisterRA_REG2] != 0) ||
                                           (useRB_REG2 && m_cnt[readRegisterRB_REG2] != 0) ||
                                           (useRC_REG2 && m_cnt[readRegisterRC_REG2] != 0));
                    dep = valid_REG1 && valid_REG2 && regWriteEnable_REG1 &&
                          ((useRA_REG2 && readRegisterRA_REG2 == readRegisterRT_REG1) ||
                           (useRB_REG2 && readRegisterRB_REG2 == readRegisterRT_REG1) ||
                           (useRC_REG2 && readRegisterRC_REG2 == readRegisterRT_REG1));
                    if (raw_e || raw_o) e = 7'b0011100;
                    else if (dep) begin e = 7'b0001110; is_e = 1; end
                    else begin is_e = valid_REG1; is_o = valid_REG2; end
                end
                n_checks++;
                if (obs !== e) begin
                    n_fail++;
                    $display("FAIL model_cmp t=%0t got=%b exp=%b (sE sO fE fO hold split redir)", $time, obs, e);
                end
                if (dec) for (int r = 0; r < 128; r++) if (m_cnt[r] > 0) m_cnt[r]--;
                if (is_e && regWriteEnable_REG1) m_cnt[readRegisterRT_REG1] = int'(latency_REG1);
                if (is_o && regWriteEnable_REG2) m_cnt[readRegisterRT_REG2] = int'(latency_REG2);
            end
        end
    end

    task automatic clear_inputs();
        valid_REG1 = 0; valid_REG2 = 0;
        regWriteEnable_REG1 = 0; regWriteEnable_REG2 = 0;
        readRegisterRA_REG1 = 0; readRegisterRB_REG1 = 0; readRegisterRC_REG1 = 0;
        readRegisterRA_REG2 = 0; readRegisterRB_REG2 = 0; readRegisterRC_REG2 = 0;
        useRA_REG1 = 0; useRB_REG1 = 0; useRC_REG1 = 0;
        useRA_REG2 = 0; useRB_REG2 = 0; useRC_REG2 = 0;
        readRegisterRT_REG1 = 0; readRegisterRT_REG2 = 0;
        latency_REG1 = 0; latency_REG2 = 0;
        mispredict = 0; stallExternal = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [6:0] exp);
        #1;
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%b exp=%b", name, obs, exp);
        end
    endtask

    task automatic read_even(input logic [6:0] r);
        clear_inputs();
        valid_REG1 = 1; useRA_REG1 = 1; readRegisterRA_REG1 = r;
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        #1;
        next_cycle();
        chk("reset_outputs", 7'b0011000);
        next_cycle();
        reset = 0;

        // RAW: RT=5 latency 3, reader waits three cycles
        clear_inputs();
        valid_REG1 = 1; regWriteEnable_REG1 = 1; readRegisterRT_REG1 = 5; latency_REG1 = 3;
        chk("raw_writer_issue", 7'b0000000);
        for (int i = 0; i < 3; i++) begin
            next_cycle(); read_even(5); chk("raw_stall", 7'b0011100);
        end
        next_cycle(); read_even(5); chk("raw_release", 7'b0000000);

        // Intra-pair: even RT=9 latency 0, odd reads 9
        next_cycle(); clear_inputs();
        valid_REG1 = 1; regWriteEnable_REG1 = 1; readRegisterRT_REG1 = 9;
        valid_REG2 = 1; useRB_REG2 = 1; readRegisterRB_REG2 = 9;
        chk("split_issue", 7'b0001110);
        next_cycle(); read_even(9); chk("split_replay", 7'b0000000);

        // Mispredict flush sequence
        next_cycle(); clear_inputs(); mispredict = 1; chk("mp_pulse", 7'b0011001);
        next_cycle(); clear_inputs(); chk("mp_flush1", 7'b0011000);
        next_cycle(); chk("mp_flush2", 7'b0011000);
        next_cycle(); chk("mp_done", 7'b0000000);
        next_cycle(); mispredict = 1; chk("mp2_pulse", 7'b0011001);
        next_cycle(); mispredict = 0; chk("mp2_flush1", 7'b0011000);
        next_cycle(); mispredict = 1; chk("mp2_reload_no_redirect", 7'b0011000);
        next_cycle(); mispredict = 0; chk("mp2_ext1", 7'b0011000);
        next_cycle(); chk("mp2_ext2", 7'b0011000);
        next_cycle(); chk("mp2_done", 7'b0000000);

        // External stall freezes cnt[7] at 2
        next_cycle(); clear_inputs();
        valid_REG1 = 1; regWriteEnable_REG1 = 1; readRegisterRT_REG1 = 7; latency_REG1 = 2;
        chk("stall_writer", 7'b0000000);
        for (int i = 0; i < 4; i++) begin
            next_cycle(); read_even(7); stallExternal = 1; chk("ext_stall", 7'b1100100);
        end
        for (int i = 0; i < 2; i++) begin
            next_cycle(); read_even(7); chk("post_stall_raw", 7'b0011100);
        end
        next_cycle(); read_even(7); chk("post_stall_issue", 7'b0000000);

        // Both slots write RT=12, odd latency 4 wins
        next_cycle(); clear_inputs();
        valid_REG1 = 1; regWriteEnable_REG1 = 1; readRegisterRT_REG1 = 12; latency_REG1 = 1;
        valid_REG2 = 1; regWriteEnable_REG2 = 1; readRegisterRT_REG2 = 12; latency_REG2 = 4;
        chk("dual_write", 7'b0000000);
        for (int i = 0; i < 4; i++) begin
            next_cycle(); read_even(12); chk("dual_write_raw", 7'b0011100);
        end
        next_cycle(); read_even(12); chk("dual_write_release", 7'b0000000);

        // Reset during flush with a busy register
        next_cycle(); clear_inputs();
        valid_REG1 = 1; regWriteEnable_REG1 = 1; readRegisterRT_REG1 = 20; latency_REG1 = 7;
        chk("busy_writer", 7'b0000000);
        next_cycle(); clear_inputs(); mispredict = 1; chk("pre_reset_mp", 7'b0011001);
        next_cycle(); clear_inputs(); reset = 1; chk("reset_mid_flush", 7'b0011000);
        next_cycle(); reset = 0; read_even(20); chk("after_reset_issue", 7'b0000000);

        // Randomized traffic, checked by the model process
        for (int i = 0; i < 3000; i++) begin
            next_cycle();
            reset               = ($urandom_range(0, 199) == 0);
            valid_REG1          = ($urandom_range(0, 3) != 0);
            valid_REG2          = ($urandom_range(0, 3) != 0);
            regWriteEnable_REG1 = $urandom_range(0, 1);
            regWriteEnable_REG2 = $urandom_range(0, 1);
            readRegisterRA_REG1 = 7'($urandom_range(0, 7));
            readRegisterRB_REG1 = 7'($urandom_range(0, 7));
            readRegisterRC_REG1 = 7'($urandom_range(0, 7));
            readRegisterRA_REG2 = 7'($urandom_range(0, 7));
            readRegisterRB_REG2 = 7'($urandom_range(0, 7));
            readRegisterRC_REG2 = 7'($urandom_range(0, 7));
            readRegisterRT_REG1 = 7'($urandom_range(0, 7));
            readRegisterRT_REG2 = 7'($urandom_range(0, 7));
            useRA_REG1 = ($urandom_range(0, 2) == 0);
            useRB_REG1 = ($urandom_range(0, 2) == 0);
            useRC_REG1 = ($urandom_range(0, 3) == 0);
            useRA_REG2 = ($urandom_range(0, 2) == 0);
            useRB_REG2 = ($urandom_range(0, 2) == 0);
            useRC_REG2 = ($urandom_range(0, 3) == 0);
            latency_REG1  = 3'($urandom_range(0, 7));
            latency_REG2  = 3'($urandom_range(0, 7));
            mispredict    = ($urandom_range(0, 19) == 0);
            stallExternal = ($urandom_range(0, 7) == 0);
        end
        next_cycle();
        clear_inputs();
        reset = 0;
        @(posedge clk);
        @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spu_issue_hazard_ctrl.md
Name: spu_issue_hazard_ctrl

Overview:
- Issue-stage hazard controller for the dual-issue SPU pipeline (even pipe 1, odd pipe 2).
- Keeps a per-register pending-write scoreboard and detects RAW hazards and intra-pair dependencies.
- Sequences branch-mispredict flushes with a small FSM.
- Drives stallEven, stallOdd, flushEven and flushOdd into the REG/EX pipeline register, plus hold/split controls back to decode.

Parameters:
- NUM_REGS, 128, architectural register count; index width is 7.
- LAT_W, 3, width of the per-register remaining-latency counter; max latency is 7.
- FLUSH_CYCLES, 2, number of cycles both pipes are bubbled after a mispredict.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- valid_REG1  in  1  even-slot instruction present at REG stage
- valid_REG2  in  1  odd-slot instruction present at REG stage
- regWriteEnable_REG1  in  1  even instruction writes RT
- regWriteEnable_REG2  in  1  odd instruction writes RT
- readRegisterRA_REG1, readRegisterRB_REG1, readRegisterRC_REG1  in  7 each  even source registers
- readRegisterRA_REG2, readRegisterRB_REG2, readRegisterRC_REG2  in  7 each  odd source registers
- useRA_REG1, useRB_REG1, useRC_REG1, useRA_REG2, useRB_REG2, useRC_REG2  in  1 each  source operand actually read
- readRegisterRT_REG1, readRegisterRT_REG2  in  7 each  destination registers
- latency_REG1, latency_REG2  in  LAT_W each  cycles until the result is forwardable; 0 = unit forwards next cycle
- mispredict  in  1  odd-pipe branch resolved as mispredicted (single-cycle pulse)
- stallExternal  in  1  global freeze request (local store busy)
- stallEven, stallOdd  out  1 each  hold REG/EX even/odd register
- flushEven, flushOdd  out  1 each  load a bubble into REG/EX even/odd register
- holdDecode  out  1  decode keeps presenting the same pair
- splitIssue  out  1  decode re-presents the odd instruction alone (in the even-slot position order) next cycle
- redirectFetch  out  1  one-cycle pulse, front end refetches from the branch target

Behaviour:
- Reset (clk edge with reset=1):
  - all scoreboard counters = 0; FSM = IDLE.
  - outputs all 0 during reset, except flushEven = flushOdd = 1.
- Scoreboard: cnt[r] is LAT_W bits, r = 0..127.
  - Each cycle every nonzero cnt decrements by 1.
  - An issuing writer then overrides: cnt[RT] = latency.
  - If both slots issue writers to the same RT, the odd slot wins.
  - No saturation issue: latency ≤ 7 by width.
- RAW hazard for a slot: any used source s with cnt[s] ≠ 0. Register 0 is not special.
- Intra-pair dependency: even writes RT, odd uses a source == even RT, and both are valid.
- Output decode, in priority order. All outputs are combinational from current state and inputs; scoreboard and FSM are registered.
  1. reset: as above.
  2. FSM = FLUSH, or mispredict = 1:
     - flushEven = flushOdd = 1; holdDecode = 0.
     - no scoreboard writes.
     - redirectFetch = 1 only on the cycle mispredict is sampled in IDLE.
  3. stallExternal:
     - stallEven = stallOdd = 1, holdDecode = 1, flush = 0.
     - scoreboard does not decrement and does not issue (frozen).
  4. even RAW, or odd RAW:
     - flushEven = flushOdd = 1 (bubble both, preserve order); holdDecode = 1; no issue.
  5. intra-pair dependency:
     - even issues; flushOdd = 1; holdDecode = 1; splitIssue = 1.
  6. otherwise: both valid slots issue; all control outputs 0.
- Invalid slots never issue, never hazard, and never write the scoreboard.
- Flush FSM:
  - IDLE→FLUSH on mispredict, loading fcnt = FLUSH_CYCLES-1.
  - In FLUSH, fcnt decrements; FLUSH→IDLE when fcnt = 0 at the clock edge.
  - A mispredict while in FLUSH reloads fcnt and produces no new redirectFetch.
  - mispredict overrides stallExternal.
  - Scoreboard keeps decrementing during FLUSH, since older instructions drain.
- Reset mid-flush or mid-stall returns to IDLE with a clear scoreboard on the next edge.

Decomposition:
- Shared package spu_pkg:
  - REG_IDX_W = 7, LAT_W, FLUSH_CYCLES default.
  - typedef reg_idx_t (logic [6:0]).
  - typedef hz_state_t enum {IDLE, FLUSH}.
- One natural sub-module: spu_scoreboard. It holds the 128 counters and provides two write ports, a freeze input, and six read ports returning busy flags.

Test Plan:
- Even issues RT=5, latency=3; next pair even reads RA=5 → flushEven = flushOdd = holdDecode = 1 for 3 cycles, issue on the 4th.
- Even RT=9 (latency 0) with odd RA=9 in the same pair → even issues, flushOdd = 1, splitIssue = 1; next cycle odd issues cleanly.
- mispredict pulse with FLUSH_CYCLES=2 → redirectFetch for 1 cycle; flushEven = flushOdd = 1 for 3 cycles (pulse cycle + 2); a second mispredict mid-flush extends the flush with no second redirect.
- stallExternal for 4 cycles with cnt[7] = 2 → stallEven = stallOdd = 1 and cnt[7] stays 2; it resumes decrementing after release.
- Both slots write RT=12 (latencies 1 and 4) → cnt[12] = 4; a reader of 12 stalls 4 cycles.
- Reset asserted during FLUSH with busy registers → FSM = IDLE and all cnt = 0; a reader of a previously busy register issues immediately after reset.
